sd_block_arbiter: RTL and testbench
===================================

// Module: sd_block_arbiter
// PURPOSE
//  Shares the single hps_io SD block channel (sd_lba/sd_rd/sd_wr/sd_ack) between NREQ requesters
//  (ZPU drive emulation, cart/save loaders). Latches per-requester block commands, grants round-robin,
//  runs the rd/wr -> ack handshake, and reports DONE/ERR per requester. GRANT steers sdbuf port B.
// PARAMETERS
//  NREQ       2    number of requesters (1..8)
//  TIMEOUT_W  24   ack-start timeout counter width; timeout after 2**TIMEOUT_W-1 cycles without SD_ACK
// PORTS
//  CLK        in   1         system clock (clk_sys domain)
//  RESET_N    in   1         asynchronous, active-low reset
//  REQ_STB    in   NREQ      1-cycle command strobe per requester
//  REQ_WRITE  in   NREQ      direction sampled with REQ_STB: 1=write, 0=read
//  REQ_LBA    in   NREQ*32   LBA per requester, slice i = [32*i+31:32*i], sampled with REQ_STB
//  REQ_PEND   out  NREQ      command latched, not yet completed
//  REQ_DONE   out  NREQ      1-cycle completion pulse
//  REQ_ERR    out  NREQ      1-cycle, coincident with REQ_DONE, on timeout
//  GRANT      out  NREQ      one-hot owner of the SD channel, all-zero when idle
//  SD_LBA     out  32        LBA of granted command
//  SD_RD      out  1         read request to hps_io
//  SD_WR      out  1         write request to hps_io
//  SD_ACK     in   1         hps_io acknowledge (high for transfer duration)
// BEHAVIOUR
//  Reset: all outputs 0, all pending regs clear, RR pointer = NREQ-1 (first grant favours req 0), state IDLE.
//  Capture: REQ_STB[i] with REQ_PEND[i]=0 -> next edge PEND[i]=1, lba[i]/wr[i] latched.
//   STB while PEND[i]=1 ignored (no latch, no error). STB in same cycle as DONE[i] -> accepted (set wins).
//  FSM IDLE -> ISSUE -> XFER -> FIN -> IDLE.
//   IDLE: if any PEND, pick first set index scanning ptr+1, ptr+2 ... (mod NREQ); register GRANT,
//    SD_LBA, SD_RD=~wr / SD_WR=wr; ptr<=index; clear timeout counter; -> ISSUE. SD_ACK ignored in IDLE.
//   ISSUE: hold SD_RD/SD_WR. SD_ACK=1 -> drop SD_RD/SD_WR next edge, -> XFER.
//    Counter increments each cycle; reaching all-ones with SD_ACK=0 -> drop SD_RD/SD_WR, set err, -> FIN.
//   XFER: wait SD_ACK falling (sampled 1 then 0) -> FIN. No timeout in XFER.
//   FIN: REQ_DONE[g]=1 (and REQ_ERR[g] if err) for exactly this cycle, PEND[g] cleared, GRANT->0 next edge, -> IDLE.
//  Latency: idle arbiter, strobe at edge t -> PEND at t+1 -> SD_RD/SD_WR and GRANT at t+2.
//   SD_ACK fall sampled at edge f -> DONE visible at f+1. Min gap between grants: 1 IDLE cycle.
//  SD_LBA and GRANT stable from ISSUE through FIN; SD_LBA holds last value when idle.
//  Exactly one of SD_RD/SD_WR high at a time; never high outside ISSUE.
//  Async reset mid-transfer: everything cleared immediately, SD_RD/SD_WR drop; no DONE issued.
//   hps_io ack in flight after reset is ignored.
//  REQ_LBA slices not granted have no effect; changing REQ_LBA after STB has no effect on latched command.
// TESTING
//  1 Read: STB[0], WRITE=0, LBA=0x00000123 -> 2 cycles later SD_RD=1, SD_LBA=0x123, GRANT=01.
//    ACK 1 for 10 cycles, then 0 -> DONE[0] 1 cycle, ERR=0, PEND=00, GRANT=00.
//  2 Contention: STB=11 same cycle, LBA0=5, LBA1=9, WRITE1=1 -> req0 served first (SD_RD, LBA 5),
//    then req1 (SD_WR, LBA 9). Re-strobe both -> req0 again, confirming RR pointer alternates.
//  3 Fairness: req0 re-strobes during every req1 transfer with req1 busy -> grants alternate 0,1,0,1; no starvation.
//  4 Timeout (TIMEOUT_W=4): STB[1], no ACK -> SD_RD drops after 15 ISSUE cycles; DONE[1]=ERR[1]=1 same cycle.
//    Late ACK ignored.
//  5 Duplicate STB: STB[0] LBA=7 then STB[0] LBA=8 while pending -> single transfer with LBA 7.
//    STB on DONE cycle -> second transfer accepted.
//  6 Reset: RESET_N low mid-XFER -> SD_RD/SD_WR/GRANT/PEND 0 asynchronously; release -> IDLE.
//    Fresh STB[1] completes normally.

Source files
------------

// File: rtl/sd_block_arbiter.sv
// Shares one hps_io SD block channel between NREQ requesters: latches block commands,
// grants round-robin, runs the rd/wr -> ack handshake and reports DONE/ERR per requester.
module sd_block_arbiter #(
  parameter int NREQ      = 2,
  parameter int TIMEOUT_W = 24
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NREQ-1:0]   REQ_STB,
  input  logic [NREQ-1:0]   REQ_WRITE,
  input  logic [NREQ*32-1:0] REQ_LBA,
  output logic [NREQ-1:0]   REQ_PEND,
  output logic [NREQ-1:0]   REQ_DONE,
  output logic [NREQ-1:0]   REQ_ERR,
  output logic [NREQ-1:0]   GRANT,
  output logic [31:0]       SD_LBA,
  output logic              SD_RD,
  output logic              SD_WR,
  input  logic              SD_ACK
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NREQ - 1);
  localparam logic [TIMEOUT_W-1:0] CNT_ONE = TIMEOUT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_XFER,
    ST_FIN
  } state_e;

  state_e               state_q, state_d;
  logic [NREQ-1:0]      pend_q, pend_d;
  logic [NREQ-1:0]      wr_q, wr_d;
  logic [31:0]          lba_q [NREQ];
  logic [31:0]          lba_d [NREQ];
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [31:0]          sd_lba_q, sd_lba_d;
  logic                 sd_rd_q, sd_rd_d;
  logic                 sd_wr_q, sd_wr_d;
  logic [NREQ-1:0]      done_q, done_d;
  logic [NREQ-1:0]      err_q, err_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] cnt_inc;

  logic                 sel_valid;
  logic [PTR_W-1:0]     sel_idx;
  logic [NREQ-1:0]      sel_oh;

  assign cnt_inc = cnt_q + CNT_ONE;

  // Round-robin pick: indices above the pointer first, then wrap to the low ones.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_oh    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!sel_valid && pend_q[i] && (i > int'(ptr_q))) begin
        sel_valid = 1'b1;
        sel_idx   = PTR_W'(i);
        sel_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!sel_valid && pend_q[i]) begin
        sel_valid = 1'b1;
        sel_idx   = PTR_W'(i);
        sel_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every _d starts from its _q (or a pulse default) so no path leaves a latch.
    state_d  = state_q;
    pend_d   = pend_q;
    wr_d     = wr_q;
    lba_d    = lba_q;
    grant_d  = grant_q;
    sd_lba_d = sd_lba_q;
    sd_rd_d  = sd_rd_q;
    sd_wr_d  = sd_wr_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    done_d   = '0;
    err_d    = '0;

    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          grant_d  = sel_oh;
          sd_lba_d = lba_q[sel_idx];
          sd_rd_d  = ~wr_q[sel_idx];
          sd_wr_d  = wr_q[sel_idx];
          ptr_d    = sel_idx;
          cnt_d    = '0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (SD_ACK) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = ST_XFER;
        end else begin
          cnt_d = cnt_inc;
          if (&cnt_inc) begin
            sd_rd_d = 1'b0;
            sd_wr_d = 1'b0;
            done_d  = grant_q;
            err_d   = grant_q;
            state_d = ST_FIN;
          end
        end
      end
      ST_XFER: begin
        // Entry already saw ACK high, so the first low sample is the falling edge.
        if (!SD_ACK) begin
          done_d  = grant_q;
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        pend_d  = pend_q & ~grant_q;
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Capture runs after the FIN clear so a strobe on the DONE cycle wins.
    for (int i = 0; i < NREQ; i++) begin
      if (REQ_STB[i] && (!pend_q[i] || done_q[i])) begin
        pend_d[i] = 1'b1;
        wr_d[i]   = REQ_WRITE[i];
        lba_d[i]  = REQ_LBA[32*i +: 32];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      wr_q     <= '0;
      // NOTE: the small per-requester LBA store is reset too, keeping SD_LBA defined from reset.
      for (int i = 0; i < NREQ; i++) lba_q[i] <= '0;
      grant_q  <= '0;
      sd_lba_q <= '0;
      sd_rd_q  <= 1'b0;
      sd_wr_q  <= 1'b0;
      done_q   <= '0;
      err_q    <= '0;
      ptr_q    <= PTR_RST;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q  <= state_d;
      pend_q   <= pend_d;
      wr_q     <= wr_d;
      lba_q    <= lba_d;
      grant_q  <= grant_d;
      sd_lba_q <= sd_lba_d;
      sd_rd_q  <= sd_rd_d;
      sd_wr_q  <= sd_wr_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign REQ_PEND = pend_q;
  assign REQ_DONE = done_q;
  assign REQ_ERR  = err_q;
  assign GRANT    = grant_q;
  assign SD_LBA   = sd_lba_q;
  assign SD_RD    = sd_rd_q;
  assign SD_WR    = sd_wr_q;

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Directed bench for sd_block_arbiter (two requesters, 4-bit timeout counter).
module tb_sd_block_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_stb;
  logic [1:0]  req_write;
  logic [63:0] req_lba;
  logic [1:0]  req_pend;
  logic [1:0]  req_done;
  logic [1:0]  req_err;
  logic [1:0]  grant;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;

  int n_checks = 0;
  int n_err    = 0;

  sd_block_arbiter #(.NREQ(2), .TIMEOUT_W(4)) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .REQ_STB   (req_stb),
    .REQ_WRITE (req_write),
    .REQ_LBA   (req_lba),
    .REQ_PEND  (req_pend),
    .REQ_DONE  (req_done),
    .REQ_ERR   (req_err),
    .GRANT     (grant),
    .SD_LBA    (sd_lba),
    .SD_RD     (sd_rd),
    .SD_WR     (sd_wr),
    .SD_ACK    (sd_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    #2 rst_n = 1'b1;
    tick(1);
  endtask

  // Entered in the first ISSUE cycle; returns in the FIN cycle of the same transfer.
  task automatic serve(input string tag, input logic [1:0] g, input logic [31:0] lba,
                       input logic w, input logic [1:0] stb_mid);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".lba"}, sd_lba, lba);
    check({tag, ".rdwr"}, 32'({sd_rd, sd_wr}), 32'({~w, w}));
    sd_ack = 1'b1;
    tick(1);
    check({tag, ".drop"}, 32'({sd_rd, sd_wr}), 32'd0);
    req_stb = stb_mid;
    tick(1);
    req_stb = 2'b00;
    tick(2);
    check({tag, ".hold"}, 32'(grant), 32'(g));
    sd_ack = 1'b0;
    tick(1);
    check({tag, ".done"}, 32'(req_done), 32'(g));
    check({tag, ".err"}, 32'(req_err), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b1;
    req_stb   = 2'b00;
    req_write = 2'b00;
    req_lba   = 64'd0;
    sd_ack    = 1'b0;
    #1 rst_n  = 1'b0;
    #1;
    check("rst.pend", 32'(req_pend), 32'd0);
    check("rst.grant", 32'(grant), 32'd0);
    check("rst.rdwr", 32'({sd_rd, sd_wr}), 32'd0);
    check("rst.donerr", 32'({req_done, req_err}), 32'd0);
    check("rst.lba", sd_lba, 32'd0);
    tick(2);
    #2 rst_n = 1'b1;
    tick(1);

    // Single read on requester 0.
    req_lba[31:0] = 32'h0000_0123;
    req_write     = 2'b00;
    req_stb       = 2'b01;
    tick(1);
    req_stb = 2'b00;
    check("t1.pend", 32'(req_pend), 32'h1);
    check("t1.nogrant", 32'(grant), 32'd0);
    tick(1);
    check("t1.grant", 32'(grant), 32'h1);
    check("t1.rd", 32'({sd_rd, sd_wr}), 32'h2);
    check("t1.lba", sd_lba, 32'h123);
    sd_ack = 1'b1;
    tick(1);
    check("t1.drop", 32'({sd_rd, sd_wr}), 32'd0);
    tick(9);
    check("t1.nodone", 32'(req_done), 32'd0);
    sd_ack = 1'b0;
    tick(1);
    check("t1.done", 32'(req_done), 32'h1);
    check("t1.err", 32'(req_err), 32'd0);
    tick(1);
    check("t1.donepulse", 32'(req_done), 32'd0);
    check("t1.pendclr", 32'(req_pend), 32'd0);
    check("t1.grantclr", 32'(grant), 32'd0);
    check("t1.lbahold", sd_lba, 32'h123);

    // Contention from a fresh reset: req0 first, then req1, then req0 again.
    do_reset();
    req_lba   = {32'd9, 32'd5};
    req_write = 2'b10;
    req_stb   = 2'b11;
    tick(1);
    req_stb = 2'b00;
    check("t2.pend", 32'(req_pend), 32'h3);
    tick(1);
    serve("t2.a", 2'b01, 32'd5, 1'b0, 2'b00);
    tick(1);
    check("t2.gap", 32'(grant), 32'd0);
    check("t2.pend1", 32'(req_pend), 32'h2);
    tick(1);
    serve("t2.b", 2'b10, 32'd9, 1'b1, 2'b00);
    tick(1);
    req_stb = 2'b11;
    tick(1);
    req_stb = 2'b00;
    tick(1);
    serve("t2.c", 2'b01, 32'd5, 1'b0, 2'b00);
    tick(2);
    serve("t2.d", 2'b10, 32'd9, 1'b1, 2'b00);
    tick(1);
    check("t2.idle", 32'(req_pend), 32'd0);

    // Fairness: req0 re-strobes during req1, req1 re-strobes on its DONE cycle.
    req_lba   = {32'h30, 32'h20};
    req_write = 2'b10;
    req_stb   = 2'b11;
    tick(1);
    req_stb = 2'b00;
    tick(1);
    serve("t3.g0", 2'b01, 32'h20, 1'b0, 2'b00);
    tick(2);
    serve("t3.g1", 2'b10, 32'h30, 1'b1, 2'b01);
    req_stb = 2'b10;
    tick(1);
    req_stb = 2'b00;
    check("t3.pendboth", 32'(req_pend), 32'h3);
    tick(1);
    serve("t3.g2", 2'b01, 32'h20, 1'b0, 2'b00);
    tick(2);
    serve("t3.g3", 2'b10, 32'h30, 1'b1, 2'b00);
    tick(1);
    check("t3.idle", 32'(req_pend), 32'd0);

    // Timeout on requester 1, then a late ACK that must be ignored.
    req_lba[63:32] = 32'h44;
    req_write      = 2'b00;
    req_stb        = 2'b10;
    tick(1);
    req_stb = 2'b00;
    tick(1);
    check("t4.issue", 32'({grant, sd_rd, sd_wr}), 32'({2'b10, 2'b10}));
    tick(14);
    check("t4.stillrd", 32'({sd_rd, sd_wr}), 32'h2);
    check("t4.notyet", 32'(req_done), 32'd0);
    tick(1);
    check("t4.drop", 32'({sd_rd, sd_wr}), 32'd0);
    check("t4.done", 32'(req_done), 32'h2);
    check("t4.err", 32'(req_err), 32'h2);
    sd_ack = 1'b1;
    tick(1);
    check("t4.pulse", 32'({req_done, req_err}), 32'd0);
    check("t4.pendclr", 32'(req_pend), 32'd0);
    tick(3);
    check("t4.lateack", 32'({grant, sd_rd, sd_wr}), 32'd0);
    sd_ack = 1'b0;
    tick(1);

    // Duplicate strobe while pending is dropped; strobe on DONE is accepted.
    req_lba[31:0] = 32'd7;
    req_stb       = 2'b01;
    tick(1);
    req_lba[31:0] = 32'd8;
    tick(1);
    req_stb = 2'b00;
    serve("t5.first", 2'b01, 32'd7, 1'b0, 2'b00);
    req_stb = 2'b01;
    tick(1);
    req_stb = 2'b00;
    check("t5.reaccept", 32'(req_pend), 32'h1);
    tick(1);
    serve("t5.second", 2'b01, 32'd8, 1'b0, 2'b00);
    tick(1);
    check("t5.idle", 32'(req_pend), 32'd0);
    tick(2);
    check("t5.nothird", 32'(grant), 32'd0);

    // Asynchronous reset in the middle of a transfer.
    req_lba[63:32] = 32'h55;
    req_write      = 2'b10;
    req_stb        = 2'b10;
    tick(1);
    req_stb = 2'b00;
    tick(1);
    check("t6.wr", 32'({sd_rd, sd_wr}), 32'h1);
    sd_ack = 1'b1;
    tick(1);
    rst_n = 1'b0;
    tick(1);
    req_stb = 2'b00;
    #1 rst_n = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t6.async", 32'({grant, req_pend, sd_rd, sd_wr}), 32'd0);
    tick(1);
    #2 rst_n = 1'b1;
    tick(2);
    check("t6.ackign", 32'({grant, req_pend, req_done}), 32'd0);
    sd_ack = 1'b0;
    tick(1);
    check("t6.nodone", 32'(req_done), 32'd0);
    req_lba[63:32] = 32'h66;
    req_write      = 2'b00;
    req_stb        = 2'b10;
    tick(1);
    req_stb = 2'b00;
    tick(1);
    serve("t6.fresh", 2'b10, 32'h66, 1'b0, 2'b00);
    tick(1);
    check("t6.idle", 32'({grant, req_pend}), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
